sr_cmd_sched: RTL and testbench

SR_CMD_SCHED -- requirements
Module: sr_cmd_sched

---
 rtl/sr_pkg.sv | 16 +
 rtl/sr_cmd_sched_rr_arbiter.sv | 27 ++
 rtl/sr_cmd_sched.sv | 138 +++++++++++++
 tb/tb_sr_cmd_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flag-bank command scheduler.
package sr_pkg;

   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned DEF_NBITS = 8;
   localparam int unsigned DEF_HOLD  = 2;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/sr_cmd_sched_rr_arbiter.sv
// Round-robin one-hot grant: search starts at ptr and wraps around.
module rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);

   logic        found;
   int unsigned j;

   always_comb begin
      grant = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = (32'(ptr) + k) % NREQ;
         if (!found && req[PW'(j)]) begin
            grant[PW'(j)] = 1'b1;
            found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_sched.sv
// Arbitrated set/reset strobe scheduler for a shared SR flag bank.
// Optional SR_CMD_SCHED_STATS_EN adds a 16-bit accepted-command counter.
module sr_cmd_sched
   import sr_pkg::*;
#(
   parameter  int unsigned NREQ  = DEF_NREQ,
   parameter  int unsigned NBITS = DEF_NBITS,
   parameter  int unsigned HOLD  = DEF_HOLD,
   localparam int unsigned IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NREQ-1:0]      req_ready,
   output logic [NBITS-1:0]     s_out,
   output logic [NBITS-1:0]     r_out,
   output logic [NBITS-1:0]     q_shadow,
   output logic                 busy,
   output logic                 err_conflict
`ifdef SR_CMD_SCHED_STATS_EN
   ,
   output logic [15:0]          cmd_count
`endif
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = 4;

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_nxt;
   logic [PW-1:0]    gidx;
   logic [NREQ-1:0]  grant;
   logic             accept;
   logic             sel_op;
   logic [IDXW-1:0]  sel_idx;
   logic [NBITS-1:0] sel_mask;
   logic             conflict_c;
   logic             op_lat;
   logic [NBITS-1:0] mask_lat;
   logic [CW-1:0]    cnt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   assign req_ready = (state == IDLE && !rst) ? grant : '0;
   assign accept    = |req_ready;

   // Payload mux of the granted requester
   always_comb begin
      sel_op  = 1'b0;
      sel_idx = '0;
      gidx    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_op  = req_op[i];
            sel_idx = req_idx[i*IDXW +: IDXW];
            gidx    = PW'(i);
         end
      end
   end

   // Out-of-range indices yield an empty mask: no strobe, no shadow update
   assign sel_mask = (32'(sel_idx) < NBITS) ? (NBITS'(1) << sel_idx) : '0;
   assign ptr_nxt  = (32'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);

   always_comb begin
      conflict_c = 1'b0;
      for (int unsigned a = 0; a < NREQ; a++) begin
         for (int unsigned b = a + 1; b < NREQ; b++) begin
            if (req_valid[a] && req_valid[b] &&
                req_idx[a*IDXW +: IDXW] == req_idx[b*IDXW +: IDXW] &&
                req_op[a] != req_op[b])
               conflict_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         cnt          <= '0;
         op_lat       <= OP_CLR;
         mask_lat     <= '0;
         s_out        <= '0;
         r_out        <= '0;
         q_shadow     <= '0;
         busy         <= 1'b0;
         err_conflict <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= DRIVE;
                  ptr      <= ptr_nxt;
                  cnt      <= CW'(HOLD - 1);
                  op_lat   <= sel_op;
                  mask_lat <= sel_mask;
                  s_out    <= (sel_op == OP_SET) ? sel_mask : '0;
                  r_out    <= (sel_op == OP_CLR) ? sel_mask : '0;
                  busy     <= 1'b1;
                  if (conflict_c)
                     err_conflict <= 1'b1;
               end
            end
            DRIVE: begin
               if (cnt == '0) begin
                  state    <= IDLE;
                  s_out    <= '0;
                  r_out    <= '0;
                  busy     <= 1'b0;
                  q_shadow <= (op_lat == OP_SET) ? (q_shadow | mask_lat)
                                                 : (q_shadow & ~mask_lat);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SR_CMD_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cmd_count <= '0;
      else if (accept)
         cmd_count <= cmd_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sr_cmd_sched.sv
// Scoreboard bench for sr_cmd_sched (NBITS=6 so out-of-range indices are reachable).
module tb_sr_cmd_sched;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned NBITS = 6;
   localparam int unsigned HOLD  = 2;
   localparam int unsigned IDXW  = 3;

   typedef struct packed {
      logic [NREQ-1:0]  grant;
      logic [NBITS-1:0] sm;
      logic [NBITS-1:0] rm;
      logic             gap;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_op;
   logic [NREQ*IDXW-1:0] req_idx;
   logic [NREQ-1:0]      req_ready;
   logic [NBITS-1:0]     s_out;
   logic [NBITS-1:0]     r_out;
   logic [NBITS-1:0]     q_shadow;
   logic                 busy;
   logic                 err_conflict;
`ifdef SR_CMD_SCHED_STATS_EN
   logic [15:0]          cmd_count;
`endif

   sr_cmd_sched #(.NREQ(NREQ), .NBITS(NBITS), .HOLD(HOLD)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_idx      (req_idx),
      .req_ready    (req_ready),
      .s_out        (s_out),
      .r_out        (r_out),
      .q_shadow     (q_shadow),
      .busy         (busy),
      .err_conflict (err_conflict)
`ifdef SR_CMD_SCHED_STATS_EN
      ,
      .cmd_count    (cmd_count)
`endif
   );

   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   exp_t             sb[$];
   exp_t             cur;
   int               drv_left = 0;
   int               cyc = 0;
   int               last_grant = 0;
   int               acc_cnt = 0;
   logic [NBITS-1:0] exp_q = '0;
   logic             rearm0 = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic op, input int idx);
      req_valid[i]              = 1'b1;
      req_op[i]                 = op;
      req_idx[i*IDXW +: IDXW]   = IDXW'(idx);
   endtask

   task automatic push(input logic [NREQ-1:0] g, input logic [NBITS-1:0] sm,
                       input logic [NBITS-1:0] rm, input logic gap);
      exp_t e;
      e.grant = g; e.sm = sm; e.rm = rm; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_idx   = '0;
      repeat (2) @(posedge clk);
      #1 rst    = 1'b0;
      exp_q     = '0;
      drv_left  = 0;
      acc_cnt   = 0;
      sb.delete();
   endtask

   // One clock: check outputs at negedge against the scoreboard, drop accepted requests after posedge
   task automatic cycle(output logic [NREQ-1:0] acc);
      @(negedge clk);
      if (drv_left > 0) begin
         check("s_out", 32'(s_out), 32'(cur.sm));
         check("r_out", 32'(r_out), 32'(cur.rm));
         check("busy_drive", 32'(busy), 32'd1);
         check("ready_drive", 32'(req_ready), 32'd0);
         drv_left--;
         if (drv_left == 0)
            exp_q = (exp_q | cur.sm) & ~cur.rm;
      end else begin
         check("busy_idle", 32'(busy), 32'd0);
         check("strobe_idle", 32'({s_out, r_out}), 32'd0);
         check("q_shadow", 32'(q_shadow), 32'(exp_q));
         if (req_ready != '0) begin
            if (sb.size() == 0) begin
               check("spurious_grant", 32'(req_ready), 32'd0);
            end else begin
               cur = sb.pop_front();
               check("grant", 32'(req_ready), 32'(cur.grant));
               if (cur.gap)
                  check("grant_gap", 32'(cyc - last_grant), 32'(HOLD + 1));
               last_grant = cyc;
               drv_left   = HOLD;
            end
         end
      end
      acc = req_valid & req_ready;
      acc_cnt += $countones(acc);
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      cyc++;
   endtask

   task automatic run_until_done();
      logic [NREQ-1:0] acc;
      int n = 0;
      while ((sb.size() > 0 || drv_left > 0 || req_valid != '0) && n < 200) begin
         cycle(acc);
         if (rearm0 && acc[0]) begin
            rearm0 = 1'b0;
            set_req(0, 1'b0, 0);
         end
         n++;
      end
      if (n >= 200)
         check("timeout", 32'd1, 32'd0);
      cycle(acc);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '1;
      req_op    = '1;
      req_idx   = '0;
      #2;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_strobes", 32'({s_out, r_out}), 32'd0);
      check("rst_q", 32'(q_shadow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_conflict), 32'd0);

      // Single set of idx3
      do_reset();
      set_req(0, 1'b1, 3);
      push(4'b0001, 6'h08, 6'h00, 1'b0);
      run_until_done();
      check("single_q", 32'(q_shadow), 32'h08);
      check("single_err", 32'(err_conflict), 32'd0);

      // All four requesters, requester 0 re-arms with a clear after its first grant
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, i);
      rearm0 = 1'b1;
      push(4'b0001, 6'h01, 6'h00, 1'b0);
      push(4'b0010, 6'h02, 6'h00, 1'b1);
      push(4'b0100, 6'h04, 6'h00, 1'b1);
      push(4'b1000, 6'h08, 6'h00, 1'b1);
      push(4'b0001, 6'h00, 6'h01, 1'b1);
      run_until_done();
      check("rr_q", 32'(q_shadow), 32'h0E);
`ifdef SR_CMD_SCHED_STATS_EN
      check("cmd_count", 32'(cmd_count), 32'(acc_cnt));
      check("cmd_count_5", 32'(cmd_count), 32'd5);
`endif

      // Opposite ops on idx5 in the same cycle
      do_reset();
      set_req(1, 1'b1, 5);
      set_req(2, 1'b0, 5);
      push(4'b0010, 6'h20, 6'h00, 1'b0);
      push(4'b0100, 6'h00, 6'h20, 1'b1);
      run_until_done();
      check("conflict_err", 32'(err_conflict), 32'd1);
      check("conflict_q", 32'(q_shadow), 32'h00);
      repeat (3) @(posedge clk);
      #1 check("conflict_sticky", 32'(err_conflict), 32'd1);

      // Reset during the second DRIVE cycle
      do_reset();
      set_req(0, 1'b1, 1);
      @(negedge clk);
      check("abort_grant", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("abort_s1", 32'(s_out), 32'h02);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_strobes", 32'({s_out, r_out}), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_q", 32'(q_shadow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b1, 2);
      set_req(1, 1'b1, 3);
      #1 check("abort_next_grant", 32'(req_ready), 32'b0001);

      // Out-of-range index: busy for HOLD cycles, no strobe, no shadow change
      do_reset();
      set_req(0, 1'b1, 1);
      push(4'b0001, 6'h02, 6'h00, 1'b0);
      run_until_done();
      set_req(1, 1'b1, 7);
      push(4'b0010, 6'h00, 6'h00, 1'b0);
      run_until_done();
      check("oor_q", 32'(q_shadow), 32'h02);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
